// File: rtl/mem_lsu_if.sv
// Core-side and bus-side handshake bundle for the load/store unit.
// master: the LSU itself. slave: the core plus bus fabric driving it.
interface mem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_valid;
  logic              cpu_wen;
  logic [2:0]        cpu_memop;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_busy;
  logic              cpu_done;
  logic [31:0]       cpu_rdata;
  logic              cpu_err;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_wstrb;
  logic              bus_gnt;
  logic              bus_resp;
  logic [31:0]       bus_rdata;

  modport master (
    input  cpu_valid, cpu_wen, cpu_memop, cpu_addr, cpu_wdata,
    input  bus_gnt, bus_resp, bus_rdata,
    output cpu_busy, cpu_done, cpu_rdata, cpu_err,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb
  );

  modport slave (
    output cpu_valid, cpu_wen, cpu_memop, cpu_addr, cpu_wdata,
    output bus_gnt, bus_resp, bus_rdata,
    input  cpu_busy, cpu_done, cpu_rdata, cpu_err,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: one outstanding core access at a time, turned into a
// word-aligned bus request with byte strobes; load data is lane-extracted
// and sign/zero-extended.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/HU/W accesses trap to an
// error completion instead of being force-aligned.
module mem_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  mem_lsu_if.master lsu
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE, S_DONE_ERR
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [31:0]       r_bus_wdata;
  logic [3:0]        r_bus_wstrb;
  logic [1:0]        r_off;
  logic [2:0]        r_memop;
  logic [31:0]       r_rdata;

  logic       w_legal_op;
  logic       w_misalign;
  logic       w_legal;
  logic [1:0] w_off;
  logic [1:0] w_eff_off;
  logic       w_size_h;
  logic       w_size_w;
  logic [3:0] w_strb;
  logic [31:0] w_wdata_sh;
  logic [31:0] w_rshift;
  logic [31:0] w_load_ext;

  assign w_off    = lsu.cpu_addr[1:0];
  assign w_size_h = (lsu.cpu_memop[1:0] == 2'b01);
  assign w_size_w = (lsu.cpu_memop[1:0] == 2'b10);

  // Decode legality of the presented memop; unsigned sizes exist only for loads.
  always_comb begin
    w_legal_op = 1'b0;
    case (lsu.cpu_memop)
      3'b000, 3'b001, 3'b010: w_legal_op = 1'b1;
      3'b100, 3'b101:         w_legal_op = ~lsu.cpu_wen;
      default:                w_legal_op = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = (w_size_h & w_off[0]) | (w_size_w & (|w_off));
  assign w_eff_off  = w_off;
`else
  // Without trapping, the offset is snapped down to the access size.
  assign w_misalign = 1'b0;
  assign w_eff_off  = w_size_w ? 2'b00 : (w_size_h ? {w_off[1], 1'b0} : w_off);
`endif

  assign w_legal    = w_legal_op & ~w_misalign;
  assign w_wdata_sh = lsu.cpu_wdata << {w_eff_off, 3'b000};

  // Byte enables for stores; loads always fetch the full word.
  always_comb begin
    w_strb = 4'b1111;
    if (lsu.cpu_wen) begin
      case (lsu.cpu_memop[1:0])
        2'b00:   w_strb = 4'b0001 << w_eff_off;
        2'b01:   w_strb = 4'b0011 << w_eff_off;
        default: w_strb = 4'b1111;
      endcase
    end
  end

  assign w_rshift = lsu.bus_rdata >> {r_off, 3'b000};

  // Extract and extend the addressed lanes of the returned word.
  always_comb begin
    w_load_ext = w_rshift;
    case (r_memop)
      3'b000:  w_load_ext = {{24{w_rshift[7]}}, w_rshift[7:0]};
      3'b001:  w_load_ext = {{16{w_rshift[15]}}, w_rshift[15:0]};
      3'b100:  w_load_ext = {24'd0, w_rshift[7:0]};
      3'b101:  w_load_ext = {16'd0, w_rshift[15:0]};
      default: w_load_ext = w_rshift;
    endcase
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (lsu.cpu_valid) w_state_next = w_legal ? S_REQ : S_DONE_ERR;
      end
      S_REQ:      if (lsu.bus_gnt)  w_state_next = S_WAIT;
      S_WAIT:     if (lsu.bus_resp) w_state_next = S_DONE;
      S_DONE:     w_state_next = S_IDLE;
      S_DONE_ERR: w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Request latching, bus handshake and load-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
      r_off       <= '0;
      r_memop     <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (lsu.cpu_valid && w_legal) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= lsu.cpu_wen;
            r_bus_addr  <= {lsu.cpu_addr[ADDR_W-1:2], 2'b00};
            r_bus_wdata <= w_wdata_sh;
            r_bus_wstrb <= w_strb;
            r_off       <= w_eff_off;
            r_memop     <= lsu.cpu_memop;
          end
        end
        S_REQ:  if (lsu.bus_gnt) r_bus_req <= 1'b0;
        S_WAIT: if (lsu.bus_resp && !r_bus_we) r_rdata <= w_load_ext;
        default: ;
      endcase
    end
  end

  assign lsu.cpu_busy  = (r_state != S_IDLE);
  assign lsu.cpu_done  = (r_state == S_DONE) || (r_state == S_DONE_ERR);
  assign lsu.cpu_err   = (r_state == S_DONE_ERR);
  assign lsu.cpu_rdata = r_rdata;
  assign lsu.bus_req   = r_bus_req;
  assign lsu.bus_we    = r_bus_we;
  assign lsu.bus_addr  = r_bus_addr;
  assign lsu.bus_wdata = r_bus_wdata;
  assign lsu.bus_wstrb = r_bus_wstrb;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, randomized accesses
// against a byte-level reference model, and a reset-mid-access sequence.
module tb_mem_lsu;

  logic clk;
  logic rst;

  mem_lsu_if #(.ADDR_W(32)) u_if ();

  mem_lsu #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .lsu (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_rdata;

  typedef struct {
    logic        wen;
    logic [2:0]  memop;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_d;
    int          resp_d;
    bit          toggle;
    logic        err;
    logic [31:0] baddr;
    logic [3:0]  strb;
    logic [31:0] bwdata;
    logic [31:0] rdata_out;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scramble core inputs mid-access (must be ignored) or park them.
  task automatic core_noise(input bit on);
    u_if.cpu_valid = on ? 1'($urandom % 2) : 1'b0;
    if (on) begin
      u_if.cpu_addr  = $urandom;
      u_if.cpu_wen   = 1'($urandom % 2);
      u_if.cpu_memop = 3'($urandom % 8);
      u_if.cpu_wdata = $urandom;
    end
  endtask

  function automatic vec_t mk(input logic wen, input logic [2:0] memop, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int gd,
                              input int rd, input bit tg, input logic err, input logic [31:0] baddr,
                              input logic [3:0] strb, input logic [31:0] bwdata,
                              input logic [31:0] rout);
    vec_t v;
    v.wen = wen; v.memop = memop; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.gnt_d = gd; v.resp_d = rd; v.toggle = tg; v.err = err; v.baddr = baddr;
    v.strb = strb; v.bwdata = bwdata; v.rdata_out = rout;
    return v;
  endfunction

  // Reference model: reasons about sizes and byte positions, not lanes/states.
  function automatic vec_t model(input vec_t vin, input logic [31:0] prev);
    vec_t v;
    int size;
    int off;
    logic legal;
    logic [31:0] val;
    v = vin;
    case (v.memop)
      3'd0, 3'd1, 3'd2: legal = 1'b1;
      3'd4, 3'd5:       legal = !v.wen;
      default:          legal = 1'b0;
    endcase
    size = (v.memop[1:0] == 2'd0) ? 1 : ((v.memop[1:0] == 2'd1) ? 2 : 4);
    off  = int'(v.addr % 4);
`ifdef LSU_MISALIGN_TRAP_EN
    if (off % size != 0) legal = 1'b0;
`else
    off = off - (off % size);
`endif
    v.err   = !legal;
    v.baddr = v.addr & 32'hFFFF_FFFC;
    v.strb  = 4'b0000;
    for (int b = 0; b < 4; b++)
      if (b >= off && b < off + size) v.strb[b] = 1'b1;
    if (!v.wen) v.strb = 4'b1111;
    v.bwdata    = v.wdata << (8 * off);
    v.rdata_out = prev;
    if (legal && !v.wen) begin
      val = 32'd0;
      for (int i = 0; i < size; i++)
        val = val | (((v.rdata >> (8 * (off + i))) & 32'hFF) << (8 * i));
      if (!v.memop[2] && size < 4 && val[8*size-1])
        val = val | ~((32'd1 << (8 * size)) - 32'd1);
      v.rdata_out = val;
    end
    return v;
  endfunction

  task automatic run_access(input vec_t v);
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_strb;
    logic        cap_we;
    logic [31:0] mask;
    $display("TXN wen=%0d op=%03b addr=%08h wdata=%08h rdata=%08h gnt_d=%0d resp_d=%0d toggle=%0d",
             v.wen, v.memop, v.addr, v.wdata, v.rdata, v.gnt_d, v.resp_d, v.toggle);
    chk("idle_busy", u_if.cpu_busy, 1'b0);
    u_if.cpu_valid = 1'b1;
    u_if.cpu_wen   = v.wen;
    u_if.cpu_memop = v.memop;
    u_if.cpu_addr  = v.addr;
    u_if.cpu_wdata = v.wdata;
    tick();
    core_noise(v.toggle);
    if (v.err) begin
      chk("err_done", u_if.cpu_done, 1'b1);
      chk("err_flag", u_if.cpu_err, 1'b1);
      chk("err_noreq", u_if.bus_req, 1'b0);
      chk("err_rdata", u_if.cpu_rdata, v.rdata_out);
      tick();
      core_noise(1'b0);
      chk("err_end_done", u_if.cpu_done, 1'b0);
      chk("err_end_busy", u_if.cpu_busy, 1'b0);
      return;
    end
    chk("req_on", u_if.bus_req, 1'b1);
    chk("req_busy", u_if.cpu_busy, 1'b1);
    chk("req_done", u_if.cpu_done, 1'b0);
    cap_addr = u_if.bus_addr; cap_wdata = u_if.bus_wdata;
    cap_strb = u_if.bus_wstrb; cap_we = u_if.bus_we;
    chk("bus_addr", u_if.bus_addr, v.baddr);
    chk("bus_wstrb", 32'(u_if.bus_wstrb), 32'(v.strb));
    chk("bus_we", u_if.bus_we, v.wen);
    if (v.wen) begin
      mask = 32'd0;
      for (int b = 0; b < 4; b++) if (v.strb[b]) mask[8*b +: 8] = 8'hFF;
      chk("bus_wdata", u_if.bus_wdata & mask, v.bwdata & mask);
    end
    for (int i = 0; i < v.gnt_d; i++) begin
      u_if.bus_resp = v.toggle ? 1'($urandom % 2) : 1'b0;
      tick();
      core_noise(v.toggle);
      chk("hold_req", u_if.bus_req, 1'b1);
      chk("hold_busy", u_if.cpu_busy, 1'b1);
      chk("hold_done", u_if.cpu_done, 1'b0);
      chk("stable_addr", u_if.bus_addr, cap_addr);
      chk("stable_wdata", u_if.bus_wdata, cap_wdata);
      chk("stable_wstrb", 32'(u_if.bus_wstrb), 32'(cap_strb));
      chk("stable_we", u_if.bus_we, cap_we);
    end
    u_if.bus_gnt = 1'b1;
    tick();
    u_if.bus_gnt  = 1'b0;
    u_if.bus_resp = 1'b0;
    core_noise(v.toggle);
    chk("wait_req", u_if.bus_req, 1'b0);
    chk("wait_busy", u_if.cpu_busy, 1'b1);
    chk("wait_done", u_if.cpu_done, 1'b0);
    for (int i = 0; i < v.resp_d; i++) begin
      u_if.bus_gnt = v.toggle ? 1'($urandom % 2) : 1'b0;
      tick();
      core_noise(v.toggle);
      chk("wait2_busy", u_if.cpu_busy, 1'b1);
      chk("wait2_done", u_if.cpu_done, 1'b0);
    end
    u_if.bus_gnt   = 1'b0;
    u_if.bus_resp  = 1'b1;
    u_if.bus_rdata = v.rdata;
    tick();
    u_if.bus_resp  = 1'b0;
    u_if.bus_rdata = $urandom;
    core_noise(1'b0);
    chk("done_pulse", u_if.cpu_done, 1'b1);
    chk("done_err", u_if.cpu_err, 1'b0);
    chk("done_busy", u_if.cpu_busy, 1'b1);
    chk("cpu_rdata", u_if.cpu_rdata, v.rdata_out);
    tick();
    chk("end_done", u_if.cpu_done, 1'b0);
    chk("end_busy", u_if.cpu_busy, 1'b0);
    chk("end_rdata", u_if.cpu_rdata, v.rdata_out);
  endtask

  logic [31:0] r8;
  logic [31:0] r9;

  initial begin
    vec_t rv;
    rst = 1'b0;
    u_if.cpu_valid = 1'b0; u_if.cpu_wen = 1'b0; u_if.cpu_memop = 3'd0;
    u_if.cpu_addr = 32'd0; u_if.cpu_wdata = 32'd0;
    u_if.bus_gnt = 1'b0; u_if.bus_resp = 1'b0; u_if.bus_rdata = 32'd0;
    repeat (3) tick();
    chk("rst_busy", u_if.cpu_busy, 1'b0);
    chk("rst_done", u_if.cpu_done, 1'b0);
    chk("rst_err", u_if.cpu_err, 1'b0);
    chk("rst_req", u_if.bus_req, 1'b0);
    chk("rst_we", u_if.bus_we, 1'b0);
    chk("rst_addr", u_if.bus_addr, 32'd0);
    chk("rst_wdata", u_if.bus_wdata, 32'd0);
    chk("rst_wstrb", 32'(u_if.bus_wstrb), 32'd0);
    chk("rst_rdata", u_if.cpu_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

`ifdef LSU_MISALIGN_TRAP_EN
    r8 = 32'h0000_1280; r9 = 32'h0000_1280;
`else
    r8 = 32'hCAFE_F00D; r9 = 32'h0000_EE00;
`endif
    tbl[0]  = mk(1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 0, 32'h8000_0004, 4'hF, 32'hDEAD_BEEF, 32'h0);
    tbl[1]  = mk(1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 32'h0, 0, 0, 0, 0, 32'h8000_0000, 4'h8, 32'hA500_0000, 32'h0);
    tbl[2]  = mk(0, 3'b000, 32'h8000_0002, 32'h0, 32'h1280_3456, 0, 0, 0, 0, 32'h8000_0000, 4'hF, 32'h0, 32'hFFFF_FF80);
    tbl[3]  = mk(0, 3'b100, 32'h8000_0002, 32'h0, 32'h1280_3456, 0, 0, 0, 0, 32'h8000_0000, 4'hF, 32'h0, 32'h0000_0080);
    tbl[4]  = mk(0, 3'b001, 32'h8000_0002, 32'h0, 32'h1280_3456, 0, 0, 0, 0, 32'h8000_0000, 4'hF, 32'h0, 32'h0000_1280);
    tbl[5]  = mk(0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 1, 32'h0, 4'h0, 32'h0, 32'h0000_1280);
    tbl[6]  = mk(1, 3'b100, 32'h8000_0000, 32'h55, 32'h0, 0, 0, 0, 1, 32'h0, 4'h0, 32'h0, 32'h0000_1280);
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[7]  = mk(0, 3'b010, 32'h8000_0002, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 1, 32'h0, 4'h0, 32'h0, r8);
    tbl[8]  = mk(0, 3'b101, 32'h8000_0001, 32'h0, 32'h00FF_EE00, 0, 0, 0, 1, 32'h0, 4'h0, 32'h0, r9);
`else
    tbl[7]  = mk(0, 3'b010, 32'h8000_0002, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 0, 32'h8000_0000, 4'hF, 32'h0, r8);
    tbl[8]  = mk(0, 3'b101, 32'h8000_0001, 32'h0, 32'h00FF_EE00, 0, 0, 0, 0, 32'h8000_0000, 4'hF, 32'h0, r9);
`endif
    tbl[9]  = mk(1, 3'b010, 32'h8000_0010, 32'h1122_3344, 32'h0, 3, 5, 1, 0, 32'h8000_0010, 4'hF, 32'h1122_3344, r9);
    tbl[10] = mk(0, 3'b001, 32'h8000_0006, 32'h0, 32'h8001_0000, 2, 1, 1, 0, 32'h8000_0004, 4'hF, 32'h0, 32'hFFFF_8001);
    tbl[11] = mk(1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 0, 0, 0, 0, 32'h8000_0000, 4'hC, 32'hBEEF_0000, 32'hFFFF_8001);

    for (int i = 0; i < 12; i++) run_access(tbl[i]);
    exp_rdata = tbl[11].rdata_out;

    for (int i = 0; i < 60; i++) begin
      rv.wen = 1'($urandom % 2); rv.memop = 3'($urandom % 8);
      rv.addr = $urandom; rv.wdata = $urandom; rv.rdata = $urandom;
      rv.gnt_d = int'($urandom % 4); rv.resp_d = int'($urandom % 4);
      rv.toggle = 1'($urandom % 2);
      rv = model(rv, exp_rdata);
      run_access(rv);
      exp_rdata = rv.rdata_out;
    end

    // Reset while the bus read is outstanding.
    $display("TXN reset-mid-access");
    u_if.cpu_valid = 1'b1; u_if.cpu_wen = 1'b0; u_if.cpu_memop = 3'b010;
    u_if.cpu_addr = 32'h8000_0100;
    tick();
    u_if.cpu_valid = 1'b0;
    u_if.bus_gnt = 1'b1;
    tick();
    u_if.bus_gnt = 1'b0;
    chk("pre_rst_busy", u_if.cpu_busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_req", u_if.bus_req, 1'b0);
    chk("midrst_busy", u_if.cpu_busy, 1'b0);
    chk("midrst_done", u_if.cpu_done, 1'b0);
    chk("midrst_addr", u_if.bus_addr, 32'd0);
    chk("midrst_rdata", u_if.cpu_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    u_if.bus_resp  = 1'b1;
    u_if.bus_rdata = 32'h1234_5678;
    tick();
    u_if.bus_resp = 1'b0;
    chk("stray_done", u_if.cpu_done, 1'b0);
    chk("stray_busy", u_if.cpu_busy, 1'b0);
    tick();
    chk("stray_done2", u_if.cpu_done, 1'b0);
    chk("stray_rdata", u_if.cpu_rdata, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
